phy_rx_unstripe: RTL and testbench
==================================

Name: phy_rx_unstripe

Overview:
- Receive-side counterpart of the 4-lane transmit mux tree.
- Consumes the serialized byte stream (8-bit data plus valid) and un-stripes it round-robin back onto 4 byte lanes.
- Buffers completed lane groups in a small FIFO and presents them to the lane consumers with a valid/ready handshake.
- Flushes partial groups after an idle gap.

Parameters:
- IDLE_MAX, 4: consecutive idle cycles (valid_in=0) with a partial group pending before that partial group is flushed; legal 1..255.
- FIFO_DEPTH, 2: group FIFO entries; power of 2, >=2.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- data_in  input  8  serialized byte
- valid_in  input  1  data_in valid this cycle
- out_ready  input  1  consumer accepts current group
- Out0  output  8  lane 0 byte (first byte of group)
- Out1  output  8  lane 1 byte
- Out2  output  8  lane 2 byte
- Out3  output  8  lane 3 byte
- valid0..valid3  output  1 each  per-lane byte valid
- out_valid  output  1  group available at FIFO head
- overflow  output  1  sticky group-dropped flag

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: Out0..3=8'h00, valid0..3=0, out_valid=0, overflow=0. Internal: lane_ptr=0, fill mask=0, idle_cnt=0, FIFO empty.
- Reset asserted mid-group or with the FIFO non-empty discards all pending data.
- Assembly FSM, two states:
  - S_IDLE: mask==0.
  - S_FILL: mask!=0.
- On each valid_in=1:
  - data_in is written to asm[lane_ptr] and mask[lane_ptr] is set.
  - lane_ptr increments (2-bit, wraps 3->0).
  - idle_cnt is cleared.
- Group complete: valid_in=1 with lane_ptr==3.
  - Push {asm with the new byte, mask=4'b1111} into the FIFO at that edge.
  - Clear mask, go to S_IDLE.
- Partial flush: in S_FILL, each valid_in=0 cycle increments idle_cnt.
  - When idle_cnt reaches IDLE_MAX, push {asm, mask}; unfilled lanes carry 8'h00.
  - Then clear mask, lane_ptr=0, idle_cnt=0, go to S_IDLE.
  - Flush never coincides with valid_in=1.
- In S_IDLE, idle_cnt holds 0.
- FIFO is first-word fall-through:
  - out_valid = !empty.
  - Out0..3 show the head data when out_valid, else 8'h00.
  - validN = head mask[N] & out_valid.
- Pop occurs on out_valid & out_ready.
- Latency: a group completed at edge N is visible on the outputs from edge N (next cycle) if the FIFO was empty; otherwise it appears in FIFO order.
- Full handling:
  - Push when full with no pop in the same cycle: the group is dropped and overflow is set.
  - overflow stays set until reset.
  - Push and pop together when full: both succeed, occupancy unchanged.
- Pop when empty is ignored.
- Outputs and state change only on rising clk.

Optional Feature:
- Macro: PHY_RX_OVF_CNT_EN.
- Defined: adds output ovf_cnt [7:0].
  - Increments on each dropped group.
  - Saturates at 8'hFF.
  - Reset to 0.
- Undefined: port and counter are absent; overflow flag only.

Decomposition:
- Package phy_rx_pkg:
  - LANES=4.
  - LANE_W=8.
  - Lane index type [1:0].
  - Group struct {data[LANES][LANE_W], mask[LANES]}.
  - FSM state enum {S_IDLE, S_FILL}.
- Sub-module phy_rx_group_fifo:
  - Parameterized FIFO_DEPTH, storing the group struct.
  - Ports: push, pop, full, empty, and head outputs.
- Top level holds the assembly FSM, idle counter, overflow logic and output gating.

Test Plan:
- Full groups:
  - Stimulus: reset, then valid_in=1 for 8 cycles with bytes 0x10..0x17, out_ready=1.
  - Required: two groups; Out0..3=10,11,12,13 then 14,15,16,17; valid0..3=1111 each; one out_valid cycle per group.
- Partial flush:
  - Stimulus: bytes 0xA0,0xA1, then valid_in=0, IDLE_MAX=4.
  - Required: exactly 4 idle cycles later, group A0,A1,00,00 with valid=1100 (valid0,valid1 high); lane_ptr back to 0 so the next byte lands in lane 0.
- Backpressure/overflow:
  - Stimulus: out_ready=0, push 3 full groups with FIFO_DEPTH=2.
  - Required: overflow=1 after the 3rd group; the first two groups drain in order when out_ready=1.
  - With PHY_RX_OVF_CNT_EN defined: ovf_cnt=1.
- Simultaneous push/pop when full:
  - Stimulus: FIFO full, out_ready=1 on the same cycle a group completes.
  - Required: no overflow; occupancy stays 2; output order preserved.
- Reset mid-group:
  - Stimulus: 3 bytes in, then reset for 1 cycle, then 4 bytes 0x20..0x23.
  - Required: all outputs 0 during reset; only group 20,21,22,23 is emitted.
- Gapped valid under threshold:
  - Stimulus: bytes with 3-cycle gaps, IDLE_MAX=4.
  - Required: no partial flush; full groups only.

Source files
------------

// File: rtl/phy_rx_pkg.sv
// phy_rx_pkg: shared lane geometry, group record and assembly state for the rx unstripe block
package phy_rx_pkg;
  localparam int LANES = 4;
  localparam int LANE_W = 8;
  typedef logic [1:0] lane_t;
  typedef struct packed {
    logic [LANES-1:0][LANE_W-1:0] data;
    logic [LANES-1:0]             mask;
  } group_t;
  typedef enum logic {S_IDLE, S_FILL} state_t;
endpackage

// File: rtl/phy_rx_group_fifo.sv
// phy_rx_group_fifo: first-word fall-through FIFO of assembled lane groups
module phy_rx_group_fifo
  import phy_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  group_t din,
  output logic   full,
  output logic   empty,
  output group_t head
);
  localparam int AW = $clog2(FIFO_DEPTH);
  group_t mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  always_comb begin
    empty = wp == rp;
    full = wp == {~rp[AW], rp[AW-1:0]};
    do_pop = pop && !empty;
    // a push into a full FIFO still lands when the head leaves on the same edge
    do_push = push && (!full || do_pop);
    head = mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + (AW+1)'(1);
      end
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
endmodule

// File: rtl/phy_rx_unstripe.sv
// phy_rx_unstripe: un-stripes a serialized byte stream round-robin onto 4 lanes via a group FIFO
// Optional PHY_RX_OVF_CNT_EN adds a saturating dropped-group counter output ovf_cnt.
module phy_rx_unstripe
  import phy_rx_pkg::*;
#(
  parameter int IDLE_MAX = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       out_ready,
  output logic [7:0] Out0,
  output logic [7:0] Out1,
  output logic [7:0] Out2,
  output logic [7:0] Out3,
  output logic       valid0,
  output logic       valid1,
  output logic       valid2,
  output logic       valid3,
  output logic       out_valid,
  output logic       overflow
`ifdef PHY_RX_OVF_CNT_EN
  ,
  output logic [7:0] ovf_cnt
`endif
);
  state_t state, state_nx;
  logic [LANES-1:0][LANE_W-1:0] asm_data;
  logic [LANES-1:0] mask;
  lane_t lane_ptr;
  logic [7:0] idle_cnt;
  logic complete, flush, push, pop, full, empty, drop;
  group_t grp, head;
  always_comb begin
    complete = valid_in && lane_ptr == 2'd3;
    flush = state == S_FILL && !valid_in && idle_cnt == 8'(IDLE_MAX - 1);
    push = complete || flush;
    pop = !empty && out_ready;
    drop = push && full && !pop;
    grp.mask = complete ? 4'b1111 : mask;
    // lanes not written in this group go out as zero
    for (int i = 0; i < LANES; i++)
      grp.data[i] = (complete && i == LANES-1) ? data_in : (mask[i] ? asm_data[i] : '0);
    state_nx = push ? S_IDLE : valid_in ? S_FILL : state;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      asm_data <= '0;
      mask <= '0;
      lane_ptr <= '0;
      idle_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      overflow <= overflow | drop;
      if (valid_in) begin
        asm_data[lane_ptr] <= data_in;
        lane_ptr <= lane_ptr + 2'd1;
      end
      if (flush) lane_ptr <= '0;
      mask <= push ? '0 : valid_in ? mask | (4'b0001 << lane_ptr) : mask;
      idle_cnt <= (valid_in || flush || state == S_IDLE) ? '0 : idle_cnt + 8'd1;
    end
`ifdef PHY_RX_OVF_CNT_EN
  always_ff @(posedge clk)
    if (reset) ovf_cnt <= '0;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
`endif
  phy_rx_group_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(grp),
    .full(full),
    .empty(empty),
    .head(head)
  );
  assign out_valid = !empty;
  assign Out0 = out_valid ? head.data[0] : '0;
  assign Out1 = out_valid ? head.data[1] : '0;
  assign Out2 = out_valid ? head.data[2] : '0;
  assign Out3 = out_valid ? head.data[3] : '0;
  assign valid0 = head.mask[0] & out_valid;
  assign valid1 = head.mask[1] & out_valid;
  assign valid2 = head.mask[2] & out_valid;
  assign valid3 = head.mask[3] & out_valid;
endmodule

// File: tb/tb_phy_rx_unstripe.sv
// tb_phy_rx_unstripe: scenario tasks plus randomized traffic against a queue-based reference model
module tb_phy_rx_unstripe;
  localparam int IDLE_MAX = 4;
  localparam int DEPTH = 2;
  logic clk = 0, reset = 1, valid_in = 0, out_ready = 0;
  logic [7:0] data_in = 0;
  logic [7:0] Out0, Out1, Out2, Out3;
  logic valid0, valid1, valid2, valid3, out_valid, overflow;
  int total = 0, bad = 0;
  typedef struct packed { logic [31:0] d; logic [3:0] m; } grp_t;
  grp_t mq[$];
  logic [7:0] pend[$];
  int idle = 0;
  bit movf = 0;
  int mcnt = 0;
`ifdef PHY_RX_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif
  always #5 clk = ~clk;
  phy_rx_unstripe #(.IDLE_MAX(IDLE_MAX), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .out_ready(out_ready),
    .Out0(Out0), .Out1(Out1), .Out2(Out2), .Out3(Out3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .out_valid(out_valid), .overflow(overflow)
`ifdef PHY_RX_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );
  wire [31:0] obs_d = {Out3, Out2, Out1, Out0};
  wire [3:0] obs_m = {valid3, valid2, valid1, valid0};

  function automatic logic [31:0] ed();
    return mq.size() > 0 ? mq[0].d : 32'h0;
  endfunction
  function automatic logic [3:0] em();
    return mq.size() > 0 ? mq[0].m : 4'h0;
  endfunction

  // drive one cycle, advance the reference model across the edge, sample 1 time unit later
  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit rdy);
    grp_t g;
    bit push, pop, full;
    reset = r; valid_in = v; data_in = d; out_ready = rdy;
    @(posedge clk);
    push = 0;
    g = '0;
    if (r) begin
      pend.delete(); mq.delete(); idle = 0; movf = 0; mcnt = 0;
    end else begin
      if (v) begin
        pend.push_back(d); idle = 0; push = pend.size() == 4;
      end else if (pend.size() > 0) begin
        idle++; push = idle == IDLE_MAX;
      end
      if (push) begin
        foreach (pend[i]) begin g.d[8*i +: 8] = pend[i]; g.m[i] = 1'b1; end
        pend.delete(); idle = 0;
      end
      full = mq.size() == DEPTH;
      pop = mq.size() > 0 && rdy;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (full && !pop) begin movf = 1; if (mcnt < 255) mcnt++; end
        else mq.push_back(g);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 1, 8'h55, 1);
    total++; if (obs_d !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=%h", obs_d, 32'h0); end
    total++; if (obs_m !== 4'h0) begin bad++; $display("FAIL reset_valid got=%b exp=%b", obs_m, 4'h0); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`ifdef PHY_RX_OVF_CNT_EN
    total++; if (ovf_cnt !== 8'h0) begin bad++; $display("FAIL reset_ovf_cnt got=%h exp=00", ovf_cnt); end
`endif
  endtask

  task automatic test_full_groups();
    grp_t seen[$];
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, i < 8, 8'(8'h10 + i), 1);
      if (out_valid) seen.push_back({obs_d, obs_m});
    end
    total++; if (seen.size() != 2) begin bad++; $display("FAIL full_count got=%0d exp=2", seen.size()); end
    total++; if (seen[0] !== {32'h13121110, 4'hf}) begin bad++; $display("FAIL full_g0 got=%h exp=%h", seen[0], {32'h13121110, 4'hf}); end
    total++; if (seen[1] !== {32'h17161514, 4'hf}) begin bad++; $display("FAIL full_g1 got=%h exp=%h", seen[1], {32'h17161514, 4'hf}); end
  endtask

  task automatic test_partial_flush();
    step(1, 0, 0, 0);
    step(0, 1, 8'hA0, 1);
    step(0, 1, 8'hA1, 1);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 1);
      total++; if (out_valid !== 1'(k == IDLE_MAX)) begin bad++; $display("FAIL flush_timing idle=%0d got=%b exp=%b", k, out_valid, k == IDLE_MAX); end
    end
    total++; if (obs_d !== 32'h0000A1A0) begin bad++; $display("FAIL flush_data got=%h exp=0000a1a0", obs_d); end
    total++; if (obs_m !== 4'b0011) begin bad++; $display("FAIL flush_valid got=%b exp=0011", obs_m); end
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'hB0 + i), 1);
    total++; if (obs_d !== 32'hB3B2B1B0 || obs_m !== 4'hf) begin bad++; $display("FAIL flush_realign got=%h/%b exp=b3b2b1b0/1111", obs_d, obs_m); end
  endtask

  task automatic test_overflow();
    logic [31:0] g[3];
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) g[i] = $urandom;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, g[i/4][8*(i%4) +: 8], 0);
      if (i == 7) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
`ifdef PHY_RX_OVF_CNT_EN
    total++; if (ovf_cnt !== 8'd1) begin bad++; $display("FAIL ovf_cnt got=%0d exp=1", ovf_cnt); end
`endif
    total++; if (obs_d !== g[0] || out_valid !== 1'b1) begin bad++; $display("FAIL ovf_head0 got=%h v=%b exp=%h", obs_d, out_valid, g[0]); end
    step(0, 0, 0, 1);
    total++; if (obs_d !== g[1] || out_valid !== 1'b1) begin bad++; $display("FAIL ovf_head1 got=%h v=%b exp=%h", obs_d, out_valid, g[1]); end
    step(0, 0, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", out_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] g[3];
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) g[i] = $urandom;
    for (int i = 0; i < 12; i++) step(0, 1, g[i/4][8*(i%4) +: 8], i == 11);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_overflow got=%b exp=0", overflow); end
    total++; if (obs_d !== g[1] || out_valid !== 1'b1) begin bad++; $display("FAIL pp_head1 got=%h v=%b exp=%h", obs_d, out_valid, g[1]); end
    step(0, 0, 0, 1);
    total++; if (obs_d !== g[2] || out_valid !== 1'b1) begin bad++; $display("FAIL pp_head2 got=%h v=%b exp=%h", obs_d, out_valid, g[2]); end
    step(0, 0, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'(8'h30 + i), 0);
    step(1, 0, 0, 0);
    total++; if (obs_d !== 32'h0 || obs_m !== 4'h0 || out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_outputs got=%h/%b/%b exp=0", obs_d, obs_m, out_valid); end
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h20 + i), 0);
    total++; if (obs_d !== 32'h23222120 || obs_m !== 4'hf) begin bad++; $display("FAIL rst_mid_group got=%h/%b exp=23222120/1111", obs_d, obs_m); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1);
      if (out_valid) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL rst_mid_extra got=%0d exp=0", extra); end
  endtask

  task automatic test_gapped();
    logic [31:0] g[2];
    grp_t seen[$];
    step(1, 0, 0, 0);
    g[0] = $urandom; g[1] = $urandom;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, g[i/4][8*(i%4) +: 8], 1);
      if (out_valid) seen.push_back({obs_d, obs_m});
      for (int k = 0; k < 3; k++) begin
        step(0, 0, 0, 1);
        if (out_valid) seen.push_back({obs_d, obs_m});
      end
    end
    total++; if (seen.size() != 2) begin bad++; $display("FAIL gap_count got=%0d exp=2", seen.size()); end
    total++; if (seen[0] !== {g[0], 4'hf}) begin bad++; $display("FAIL gap_g0 got=%h exp=%h", seen[0], {g[0], 4'hf}); end
    total++; if (seen[1] !== {g[1], 4'hf}) begin bad++; $display("FAIL gap_g1 got=%h exp=%h", seen[1], {g[1], 4'hf}); end
  endtask

  task automatic test_random();
    int gap = 0;
    bit v;
    step(1, 0, 0, 0);
    for (int c = 0; c < 800; c++) begin
      v = gap == 0;
      if (gap > 0) gap--;
      else if ($urandom_range(0, 3) == 0) gap = $urandom_range(1, 7);
      step(c == 400, v, 8'($urandom), $urandom_range(0, 9) < 6);
      total++;
      if (out_valid !== (mq.size() > 0) || obs_d !== ed() || obs_m !== em() || overflow !== movf) begin
        bad++;
        $display("FAIL random c=%0d got v=%b d=%h m=%b ovf=%b exp v=%b d=%h m=%b ovf=%b",
                 c, out_valid, obs_d, obs_m, overflow, mq.size() > 0, ed(), em(), movf);
      end
`ifdef PHY_RX_OVF_CNT_EN
      total++;
      if (ovf_cnt !== 8'(mcnt)) begin bad++; $display("FAIL random_ovf_cnt c=%0d got=%0d exp=%0d", c, ovf_cnt, mcnt); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_full_groups();
    test_partial_flush();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_gapped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
